// File: rtl/ans_freq_table_loader_pkg.sv
// Shared definitions for the ANS frequency-table loader and the decoder that consumes its tables.
package ans_freq_table_loader_pkg;

    localparam int SYM_WIDTH_DEF   = 4;
    localparam int SYM_COUNT_DEF   = 16;
    localparam int CNT_WIDTH_DEF   = 4;
    localparam int STATE_WIDTH     = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_LOAD  = 2'd0,
        ST_SUM   = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Start bit of entry j in a flat vector of fixed-width entries.
    function automatic int unsigned entry_lsb(input int unsigned j, input int unsigned width);
        return j * width;
    endfunction

endpackage

// File: rtl/ans_freq_table_loader_if.sv
// Nibble-serial valid/ready stream carrying the symbol frequency table.
interface ans_freq_table_loader_if #(
    parameter int SYM_WIDTH = 4
) ();
    logic [SYM_WIDTH-1:0] in;
    logic                 in_vld;
    logic                 in_rdy;

    modport master (output in, output in_vld, input in_rdy);
    modport slave  (input in, input in_vld, output in_rdy);
endinterface

// File: rtl/ans_freq_table_loader.sv
// Loads per-symbol counts MSB-nibble first, then builds inclusive cumulative sums one symbol per cycle.
module ans_freq_table_loader
    import ans_freq_table_loader_pkg::*;
#(
    parameter int SYM_WIDTH = SYM_WIDTH_DEF,
    parameter int SYM_COUNT = SYM_COUNT_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       en,
    input  logic                                       clear,
    ans_freq_table_loader_if.slave                     in_if,
    output logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked,
    output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
    output logic                                       table_vld,
    output logic                                       table_err
);

    localparam int NPC       = CNT_WIDTH / SYM_WIDTH;
    localparam int ACC_WIDTH = CNT_WIDTH + SYM_WIDTH;
    localparam int NIB_WIDTH = (NPC > 1) ? $clog2(NPC) : 1;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_counts [SYM_COUNT];
    logic [ACC_WIDTH-1:0]   r_cum    [SYM_COUNT];
    logic [SYM_WIDTH-1:0]   r_sym_idx;
    logic [NIB_WIDTH-1:0]   r_nib_idx;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_table_vld;
    logic                   r_table_err;

    logic                   w_in_rdy;
    logic                   w_last_nib;
    logic                   w_last_sym;
    logic [CNT_WIDTH-1:0]   w_count_shift;
    logic [ACC_WIDTH-1:0]   w_acc_next;

    assign w_in_rdy     = en && (r_state == ST_LOAD);
    assign in_if.in_rdy = w_in_rdy;
    assign w_last_nib   = (r_nib_idx == NIB_WIDTH'(NPC - 1));
    assign w_last_sym   = (r_sym_idx == SYM_WIDTH'(SYM_COUNT - 1));
    assign w_acc_next   = r_acc + {{SYM_WIDTH{1'b0}}, r_counts[r_sym_idx]};

    // Earlier nibbles move toward the MSB as each new nibble arrives.
    generate
        if (NPC == 1) begin : g_single_nib
            assign w_count_shift = in_if.in;
        end else begin : g_multi_nib
            assign w_count_shift = {r_counts[r_sym_idx][CNT_WIDTH-SYM_WIDTH-1:0], in_if.in};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_sym_idx   <= '0;
            r_nib_idx   <= '0;
            r_acc       <= '0;
            r_table_vld <= 1'b0;
            r_table_err <= 1'b0;
            for (int i = 0; i < SYM_COUNT; i++) begin
                r_counts[i] <= '0;
                r_cum[i]    <= '0;
            end
        end else if (en) begin
            if (clear) begin
                // Wins over a same-cycle transfer: that nibble is dropped.
                r_state     <= ST_LOAD;
                r_sym_idx   <= '0;
                r_nib_idx   <= '0;
                r_acc       <= '0;
                r_table_vld <= 1'b0;
                r_table_err <= 1'b0;
                for (int i = 0; i < SYM_COUNT; i++) begin
                    r_counts[i] <= '0;
                    r_cum[i]    <= '0;
                end
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (in_if.in_vld) begin
                            r_counts[r_sym_idx] <= w_count_shift;
                            if (w_last_nib) begin
                                r_nib_idx <= '0;
                                if (w_last_sym) begin
                                    r_sym_idx <= '0;
                                    r_acc     <= '0;
                                    r_state   <= ST_SUM;
                                end else begin
                                    r_sym_idx <= r_sym_idx + 1'b1;
                                end
                            end else begin
                                r_nib_idx <= r_nib_idx + 1'b1;
                            end
                        end
                    end
                    ST_SUM: begin
                        r_cum[r_sym_idx] <= w_acc_next;
                        r_acc            <= w_acc_next;
                        if (w_last_sym) begin
                            r_sym_idx   <= '0;
                            r_state     <= ST_READY;
                            r_table_vld <= 1'b1;
                            r_table_err <= (w_acc_next == '0);
                        end else begin
                            r_sym_idx <= r_sym_idx + 1'b1;
                        end
                    end
                    ST_READY: begin
                    end
                    default: begin
                        r_state <= ST_LOAD;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < SYM_COUNT; gi++) begin : g_pack
            assign counts_unpacked[entry_lsb(gi, CNT_WIDTH) +: CNT_WIDTH]     = r_counts[gi];
            assign cumulative_unpacked[entry_lsb(gi, ACC_WIDTH) +: ACC_WIDTH] = r_cum[gi];
        end
    endgenerate

    assign table_vld = r_table_vld;
    assign table_err = r_table_err;

endmodule

// File: tb/tb_ans_freq_table_loader.sv
// Directed bench for the frequency-table loader with a table-level reference model.
module tb_ans_freq_table_loader;

    localparam int SW  = 4;
    localparam int SC  = 16;
    localparam int CW  = 4;
    localparam int AW  = CW + SW;
    localparam int NPC = CW / SW;
    localparam int TOT = SC * NPC;
    localparam int CW8 = 8;
    localparam int AW8 = CW8 + SW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic clear = 1'b0;
    logic en8 = 1'b1;
    logic clear8 = 1'b0;

    always #5 clk = ~clk;

    ans_freq_table_loader_if #(.SYM_WIDTH(SW)) bus ();
    ans_freq_table_loader_if #(.SYM_WIDTH(SW)) bus8 ();

    logic [CW*SC-1:0]  counts;
    logic [AW*SC-1:0]  cum;
    logic              vld;
    logic              err;
    logic [CW8*SC-1:0] counts8;
    logic [AW8*SC-1:0] cum8;
    logic              vld8;
    logic              err8;

    ans_freq_table_loader #(.SYM_WIDTH(SW), .SYM_COUNT(SC), .CNT_WIDTH(CW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en),
        .clear               (clear),
        .in_if               (bus),
        .counts_unpacked     (counts),
        .cumulative_unpacked (cum),
        .table_vld           (vld),
        .table_err           (err)
    );

    ans_freq_table_loader #(.SYM_WIDTH(SW), .SYM_COUNT(SC), .CNT_WIDTH(CW8)) dut8 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en8),
        .clear               (clear8),
        .in_if               (bus8),
        .counts_unpacked     (counts8),
        .cumulative_unpacked (cum8),
        .table_vld           (vld8),
        .table_err           (err8)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the accepted nibble stream plus how many cumulative entries are finished.
    logic [SW-1:0] m_nib [TOT];
    int            m_n;
    int            m_k;
    bit            chk_on = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0;
            m_k <= 0;
            for (int i = 0; i < TOT; i++) m_nib[i] <= '0;
        end else if (en) begin
            if (clear) begin
                m_n <= 0;
                m_k <= 0;
                for (int i = 0; i < TOT; i++) m_nib[i] <= '0;
            end else if (m_n < TOT) begin
                if (bus.in_vld) begin
                    m_nib[m_n] <= bus.in;
                    m_n        <= m_n + 1;
                end
            end else if (m_k < SC) begin
                m_k <= m_k + 1;
            end
        end
    end

    function automatic int exp_count(input int j);
        int v;
        v = 0;
        for (int p = 0; p < NPC; p++) begin
            if (j * NPC + p < m_n) v = (v << SW) | int'(m_nib[j * NPC + p]);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin : cmp
            logic [CW*SC-1:0] ec;
            logic [AW*SC-1:0] eu;
            int               run;
            int               cv;
            ec  = '0;
            eu  = '0;
            run = 0;
            for (int j = 0; j < SC; j++) begin
                cv = exp_count(j);
                ec[j*CW +: CW] = cv[CW-1:0];
                run += cv;
                if (j < m_k) eu[j*AW +: AW] = run[AW-1:0];
            end
            check("model_in_rdy", bus.in_rdy, en && (m_n < TOT));
            check("model_counts", counts, ec);
            check("model_cum", cum, eu);
            check("model_vld", vld, m_k == SC);
            check("model_err", err, (m_k == SC) && (run == 0));
        end
    end

    function automatic logic [AW-1:0] cum_at(input int j);
        return cum[j*AW +: AW];
    endfunction

    logic [SW-1:0] tbl [SC];

    task automatic send_nib(input logic [SW-1:0] v);
        bit got;
        int guard;
        got   = 1'b0;
        guard = 0;
        bus.in     = v;
        bus.in_vld = 1'b1;
        while (!got && guard < 100) begin
            @(negedge clk);
            got = bus.in_rdy;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: nibble %0h not accepted within 100 cycles", v);
        end
    endtask

    task automatic send_table(input bit toggle, output int cycles);
        int t0;
        t0 = int'($time);
        for (int j = 0; j < SC; j++) begin
            send_nib(tbl[j]);
            if (toggle && j < SC - 1) begin
                bus.in_vld = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.in_vld = 1'b0;
        cycles = (int'($time) - t0) / 10;
    endtask

    task automatic wait_vld(input string name, input int exp_lat, input int stall_at, input int stall_len);
        int cycles;
        cycles = 0;
        while (!vld && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (stall_len > 0) begin
                if (cycles == stall_at) en = 1'b0;
                if (cycles == stall_at + stall_len) en = 1'b1;
            end
        end
        en = 1'b1;
        check(name, cycles, exp_lat);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int               cyc;
        logic [AW*SC-1:0] ramp;
        bit               got;
        int               acc8;
        int               lat8;

        bus.in      = '0;
        bus.in_vld  = 1'b0;
        bus8.in     = '0;
        bus8.in_vld = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        @(negedge clk);
        check("reset_vld", vld, 1'b0);
        check("reset_cum", cum, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All ones, back to back.
        for (int j = 0; j < SC; j++) tbl[j] = 4'd1;
        send_table(1'b0, cyc);
        check("ones_accept_cycles", cyc, 16);
        wait_vld("ones_latency", 16, 0, 0);
        check("ones_cum0", cum_at(0), 8'd1);
        check("ones_cum7", cum_at(7), 8'd8);
        check("ones_cum15", cum_at(15), 8'd16);
        check("ones_err", err, 1'b0);
        do_clear();

        // Sparse table 3,0,5,0...,8.
        for (int j = 0; j < SC; j++) tbl[j] = 4'd0;
        tbl[0]  = 4'd3;
        tbl[2]  = 4'd5;
        tbl[15] = 4'd8;
        send_table(1'b0, cyc);
        wait_vld("sparse_latency", 16, 0, 0);
        check("sparse_cum0", cum_at(0), 8'd3);
        check("sparse_cum1", cum_at(1), 8'd3);
        check("sparse_cum2", cum_at(2), 8'd8);
        check("sparse_cum14", cum_at(14), 8'd8);
        check("sparse_cum15", cum_at(15), 8'd16);
        check("sparse_cnt0", counts[3:0], 4'd3);
        check("sparse_cnt15", counts[63:60], 4'd8);
        do_clear();

        // Maximum counts: no wrap.
        for (int j = 0; j < SC; j++) tbl[j] = 4'd15;
        send_table(1'b0, cyc);
        wait_vld("max_latency", 16, 0, 0);
        check("max_cum15", cum_at(15), 8'hF0);
        check("max_err", err, 1'b0);
        do_clear();

        // All zero: usable but flagged.
        for (int j = 0; j < SC; j++) tbl[j] = 4'd0;
        send_table(1'b0, cyc);
        wait_vld("zero_latency", 16, 0, 0);
        check("zero_vld", vld, 1'b1);
        check("zero_err", err, 1'b1);
        do_clear();

        // Toggled valid and a three-cycle enable gap during SUM.
        for (int j = 0; j < SC; j++) tbl[j] = 4'd1;
        send_table(1'b1, cyc);
        check("toggle_accept_cycles", cyc, 31);
        wait_vld("stall_latency", 19, 5, 3);
        ramp = '0;
        for (int j = 0; j < SC; j++) ramp[j*AW +: AW] = AW'(j + 1);
        check("toggle_cum_table", cum, ramp);
        check("toggle_counts", counts, {SC{4'd1}});

        // Clear from READY, then all twos.
        do_clear();
        check("clear_vld", vld, 1'b0);
        check("clear_counts", counts, '0);
        for (int j = 0; j < SC; j++) tbl[j] = 4'd2;
        send_table(1'b0, cyc);
        wait_vld("twos_latency", 16, 0, 0);
        check("twos_cum15", cum_at(15), 8'd32);
        do_clear();

        // Asynchronous reset after seven nibbles.
        for (int j = 0; j < SC; j++) tbl[j] = SW'(j);
        for (int j = 0; j < 7; j++) send_nib(tbl[j]);
        bus.in_vld = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_mid_counts", counts, '0);
        check("rst_mid_vld", vld, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_table(1'b0, cyc);
        wait_vld("reload_latency", 16, 0, 0);
        check("reload_cum15", cum_at(15), 8'd120);
        check("reload_cnt1", counts[7:4], 4'd1);
        check("reload_err", err, 1'b0);

        // Eight-bit counts: two nibbles per symbol.
        check("w8_idle_vld", vld8, 1'b0);
        acc8 = 0;
        for (int k = 0; k < 2 * SC; k++) begin
            bus8.in     = (k == 0) ? 4'hA : ((k == 1) ? 4'h5 : 4'h0);
            bus8.in_vld = 1'b1;
            got = 1'b0;
            for (int g = 0; g < 50 && !got; g++) begin
                @(negedge clk);
                got = bus8.in_rdy;
                @(posedge clk);
                #1;
            end
            if (got) acc8++;
        end
        bus8.in_vld = 1'b0;
        check("w8_transfers", acc8, 32);
        @(negedge clk);
        check("w8_rdy_after_load", bus8.in_rdy, 1'b0);
        lat8 = 0;
        @(posedge clk);
        #1;
        lat8 = 1;
        while (!vld8 && lat8 < 200) begin
            @(posedge clk);
            #1;
            lat8++;
        end
        check("w8_latency", lat8, 16);
        check("w8_counts", counts8, {{(CW8*(SC-1)){1'b0}}, 8'hA5});
        check("w8_cum0", cum8[AW8-1:0], 12'h0A5);
        check("w8_cum15", cum8[15*AW8 +: AW8], 12'h0A5);
        check("w8_err", err8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
